// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix multiply-accumulate engine.
//   state_e    : engine control states (IDLE, COMPUTE, OUTPUT)
//   acc_width  : accumulator width for DW-bit operands summed over K terms
//   idx_width  : counter width able to address 0..n-1 (minimum 1 bit)
package matrix_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    OUTPUT  = 2'd2
  } state_e;

  // Full product is 2*DW bits; summing K of them needs clog2(K) more, plus a sign bit.
  function automatic int unsigned acc_width(input int unsigned dw, input int unsigned k);
    return 2 * dw + unsigned'($clog2(k)) + 1;
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? unsigned'($clog2(n)) : 1;
  endfunction

endpackage

// File: rtl/mac_unit.sv
// Single multiply-accumulate lane.
//   clk, reset_n : clock and asynchronous active-low reset
//   en_i         : perform one MAC this cycle
//   last_i       : this MAC completes an output element; accumulator restarts at 0
//   clear_i      : discard the running sum (job cancel)
//   signed_i     : 1 = two's-complement operands, 0 = unsigned
//   a_i, b_i     : DW-bit operands
//   sum_c_o      : combinational running sum including the current product
module mac_unit #(
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 34
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en_i,
  input  logic                 last_i,
  input  logic                 clear_i,
  input  logic                 signed_i,
  input  logic [DW-1:0]        a_i,
  input  logic [DW-1:0]        b_i,
  output logic signed [AW-1:0] sum_c_o
);

  // Operands widened so one multiplier serves both signed and unsigned modes.
  localparam int unsigned PW = 2 * DW + 2;

  logic [PW-1:0]        a_x;
  logic [PW-1:0]        b_x;
  logic signed [PW-1:0] prod;
  logic signed [AW-1:0] prod_ext;
  logic signed [AW-1:0] acc_q;
  logic signed [AW-1:0] acc_d;

  // Sign- or zero-extend operands depending on mode.
  assign a_x = {{(DW + 2){signed_i & a_i[DW-1]}}, a_i};
  assign b_x = {{(DW + 2){signed_i & b_i[DW-1]}}, b_i};

  // Low PW bits of the widened product are exact in both modes.
  assign prod     = $signed(a_x * b_x);
  assign prod_ext = AW'(prod);
  assign sum_c_o  = acc_q + prod_ext;

  // Accumulator next value.
  always_comb begin
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = last_i ? '0 : sum_c_o;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/matrix_mac_engine.sv
// Sequential matrix multiply C = A x B, one MAC per cycle.
//   clk, reset_n         : clock and asynchronous active-low reset
//   in_valid / in_ready  : job handshake; A, B, signed_en, sat_en captured on accept
//   A (M*K*DW), B (K*N*DW): row-major operand matrices
//   signed_en            : operand interpretation for the job
//   sat_en               : clamp results to OW (1) or keep low OW bits (0)
//   abort                : cancel the running job
//   C (M*N*OW)           : row-major result matrix
//   out_valid / out_ready: result handshake
//   sat_flag             : some element of C was clamped
module matrix_mac_engine
  import matrix_pkg::*;
#(
  parameter int unsigned M  = 2,
  parameter int unsigned K  = 2,
  parameter int unsigned N  = 2,
  parameter int unsigned DW = 16,
  parameter int unsigned OW = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [M*K*DW-1:0] A,
  input  logic [K*N*DW-1:0] B,
  input  logic              signed_en,
  input  logic              sat_en,
  input  logic              abort,
  output logic [M*N*OW-1:0] C,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sat_flag
);

  localparam int unsigned AW = acc_width(DW, K);
  // Wide enough to hold both the sum and any clamp limit as signed values.
  localparam int unsigned EW = ((AW > OW) ? AW : OW) + 1;
  localparam int unsigned MW = idx_width(M);
  localparam int unsigned KW = idx_width(K);
  localparam int unsigned NW = idx_width(N);

  state_e              state_q, state_d;
  logic [MW-1:0]       i_q, i_d;
  logic [NW-1:0]       j_q, j_d;
  logic [KW-1:0]       k_q, k_d;
  logic [M*K*DW-1:0]   a_q, a_d;
  logic [K*N*DW-1:0]   b_q, b_d;
  logic                signed_q, signed_d;
  logic                sat_en_q, sat_en_d;
  logic [M*N*OW-1:0]   c_q, c_d;
  logic                sat_flag_q, sat_flag_d;
  logic                out_valid_q, out_valid_d;
  logic                in_ready_q, in_ready_d;

  logic [DW-1:0]        a_el;
  logic [DW-1:0]        b_el;
  logic                 mac_en;
  logic                 mac_clear;
  logic                 k_last;
  logic                 j_last;
  logic                 i_last;
  logic signed [AW-1:0] sum_c;
  logic signed [EW-1:0] sum_e;
  logic signed [EW-1:0] hi_lim;
  logic signed [EW-1:0] lo_lim;
  logic                 clamp_hi;
  logic                 clamp_lo;
  logic                 clamp_c;
  logic [OW-1:0]        res_c;
  int unsigned          c_base;

  assign k_last = (k_q == KW'(K - 1));
  assign j_last = (j_q == NW'(N - 1));
  assign i_last = (i_q == MW'(M - 1));

  // Operand select: A(i,k) and B(k,j) from the captured job.
  assign a_el = a_q[(32'(i_q) * K + 32'(k_q)) * DW +: DW];
  assign b_el = b_q[(32'(k_q) * N + 32'(j_q)) * DW +: DW];

  mac_unit #(
    .DW (DW),
    .AW (AW)
  ) u_mac (
    .clk      (clk),
    .reset_n  (reset_n),
    .en_i     (mac_en),
    .last_i   (k_last),
    .clear_i  (mac_clear),
    .signed_i (signed_q),
    .a_i      (a_el),
    .b_i      (b_el),
    .sum_c_o  (sum_c)
  );

  // Result narrowing: clamp to the OW range of the job's mode, or wrap.
  always_comb begin
    sum_e    = EW'(sum_c);
    hi_lim   = signed_q ? EW'({(OW - 1){1'b1}}) : EW'({OW{1'b1}});
    lo_lim   = signed_q ? ~EW'({(OW - 1){1'b1}}) : '0;
    clamp_hi = sat_en_q && (sum_e > hi_lim);
    clamp_lo = sat_en_q && (sum_e < lo_lim);
    clamp_c  = clamp_hi | clamp_lo;
    if (clamp_hi) begin
      res_c = OW'(hi_lim);
    end else if (clamp_lo) begin
      res_c = OW'(lo_lim);
    end else begin
      res_c = OW'(sum_e);
    end
  end

  // Next-state and datapath control.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    k_d         = k_q;
    a_d         = a_q;
    b_d         = b_q;
    signed_d    = signed_q;
    sat_en_d    = sat_en_q;
    c_d         = c_q;
    sat_flag_d  = sat_flag_q;
    out_valid_d = out_valid_q;
    in_ready_d  = in_ready_q;
    mac_en      = 1'b0;
    mac_clear   = 1'b0;
    c_base      = '0;

    unique case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (in_valid) begin
          state_d    = COMPUTE;
          a_d        = A;
          b_d        = B;
          signed_d   = signed_en;
          sat_en_d   = sat_en;
          sat_flag_d = 1'b0;
          i_d        = '0;
          j_d        = '0;
          k_d        = '0;
        end
      end

      COMPUTE: begin
        if (abort) begin
          state_d   = IDLE;
          mac_clear = 1'b1;
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
        end else begin
          mac_en = 1'b1;
          if (k_last) begin
            // Element (i,j) complete: commit it and step to the next element.
            k_d              = '0;
            c_base           = (32'(i_q) * N + 32'(j_q)) * OW;
            c_d[c_base +: OW] = res_c;
            sat_flag_d       = sat_flag_q | clamp_c;
            if (j_last) begin
              j_d = '0;
              if (i_last) begin
                i_d     = '0;
                state_d = OUTPUT;
              end else begin
                i_d = i_q + MW'(1);
              end
            end else begin
              j_d = j_q + NW'(1);
            end
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end

      OUTPUT: begin
        // First OUTPUT cycle raises out_valid; abort overrides the handshake.
        if (abort || (out_valid_q && out_ready)) begin
          state_d     = IDLE;
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      default: begin
        state_d     = IDLE;
        out_valid_d = 1'b0;
      end
    endcase

    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      i_q         <= '0;
      j_q         <= '0;
      k_q         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      signed_q    <= 1'b0;
      sat_en_q    <= 1'b0;
      c_q         <= '0;
      sat_flag_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      i_q         <= i_d;
      j_q         <= j_d;
      k_q         <= k_d;
      a_q         <= a_d;
      b_q         <= b_d;
      signed_q    <= signed_d;
      sat_en_q    <= sat_en_d;
      c_q         <= c_d;
      sat_flag_q  <= sat_flag_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sat_flag  = sat_flag_q;
  assign C         = c_q;

endmodule

// File: tb/tb_matrix_mac_engine.sv
// Bench for matrix_mac_engine: three configurations share one clock.
//   u_dut0 : M=K=N=2, DW=16, OW=32
//   u_dut1 : M=K=N=2, DW=16, OW=16
//   u_dut2 : M=2, K=3, N=2, DW=16, OW=32
module tb_matrix_mac_engine;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic in_valid, abort, out_ready, signed_en, sat_en;
  int   sel = 0;

  logic [15:0] a_m [0:1][0:2];
  logic [15:0] b_m [0:2][0:1];
  logic [63:0] A0, B0;
  logic [95:0] A2, B2;

  logic [2:0]   irdy, oval, sflg;
  logic [127:0] C0, C2;
  logic [63:0]  C1;
  logic iv0, iv1, iv2, ab0, ab1, ab2;

  int n_pass = 0;
  int n_tot  = 0;

  assign iv0 = in_valid & (sel == 0);
  assign iv1 = in_valid & (sel == 1);
  assign iv2 = in_valid & (sel == 2);
  assign ab0 = abort & (sel == 0);
  assign ab1 = abort & (sel == 1);
  assign ab2 = abort & (sel == 2);

  always_comb begin
    A0 = '0; B0 = '0; A2 = '0; B2 = '0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 3; k++) begin
        A2[(i*3+k)*16 +: 16] = a_m[i][k];
        if (k < 2) A0[(i*2+k)*16 +: 16] = a_m[i][k];
      end
    for (int k = 0; k < 3; k++)
      for (int j = 0; j < 2; j++) begin
        B2[(k*2+j)*16 +: 16] = b_m[k][j];
        if (k < 2) B0[(k*2+j)*16 +: 16] = b_m[k][j];
      end
  end

  matrix_mac_engine #(.M(2), .K(2), .N(2), .DW(16), .OW(32)) u_dut0 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv0), .in_ready(irdy[0]), .A(A0), .B(B0),
    .signed_en(signed_en), .sat_en(sat_en), .abort(ab0), .C(C0), .out_valid(oval[0]),
    .out_ready(out_ready), .sat_flag(sflg[0]));

  matrix_mac_engine #(.M(2), .K(2), .N(2), .DW(16), .OW(16)) u_dut1 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv1), .in_ready(irdy[1]), .A(A0), .B(B0),
    .signed_en(signed_en), .sat_en(sat_en), .abort(ab1), .C(C1), .out_valid(oval[1]),
    .out_ready(out_ready), .sat_flag(sflg[1]));

  matrix_mac_engine #(.M(2), .K(3), .N(2), .DW(16), .OW(32)) u_dut2 (
    .clk(clk), .reset_n(rst_n), .in_valid(iv2), .in_ready(irdy[2]), .A(A2), .B(B2),
    .signed_en(signed_en), .sat_en(sat_en), .abort(ab2), .C(C2), .out_valid(oval[2]),
    .out_ready(out_ready), .sat_flag(sflg[2]));

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tot++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  function automatic logic [63:0] get_c(input int s, input int i, input int j);
    logic [31:0] t;
    int b;
    b = i * 2 + j;
    case (s)
      0:       t = C0[b*32 +: 32];
      1:       t = 32'(C1[b*16 +: 16]);
      default: t = C2[b*32 +: 32];
    endcase
    return 64'(t);
  endfunction

  // ---------------- behavioural model ----------------
  int          m_phase = 0;   // 0 idle, 1 busy, 2 result offered
  int          m_cnt   = 0;
  logic        m_sat   = 1'b0;
  logic [63:0] m_c [0:1][0:1];

  function automatic longint opval(input logic [15:0] x);
    if (signed_en) return longint'($signed(x));
    return longint'(x);
  endfunction

  function automatic int kdim();
    return (sel == 2) ? 3 : 2;
  endfunction

  // Reference result from the job's matrices with plain integer arithmetic.
  function automatic void model_job();
    int     ow;
    longint hi, lo, mask, s, v;
    ow   = (sel == 1) ? 16 : 32;
    mask = (64'sd1 <<< ow) - 1;
    hi   = signed_en ? (64'sd1 <<< (ow - 1)) - 1 : mask;
    lo   = signed_en ? -(64'sd1 <<< (ow - 1)) : 64'sd0;
    m_sat = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 2; j++) begin
        s = 0;
        for (int k = 0; k < kdim(); k++) s += opval(a_m[i][k]) * opval(b_m[k][j]);
        if (sat_en && s > hi) begin v = hi; m_sat = 1'b1; end
        else if (sat_en && s < lo) begin v = lo; m_sat = 1'b1; end
        else v = s;
        m_c[i][j] = 64'(v & mask);
      end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_cnt   = 0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin m_phase = 1; m_cnt = 0; model_job(); end
        1: if (abort) m_phase = 0;
           else begin
             m_cnt++;
             if (m_cnt == 4 * kdim() + 1) m_phase = 2;
           end
        default: if (abort || out_ready) m_phase = 0;
      endcase
    end
  end

  // Per-cycle compare of the active configuration against the model.
  always @(negedge clk) begin
    chk("mon_in_ready", 64'(irdy[sel]), 64'(m_phase == 0));
    chk("mon_out_valid", 64'(oval[sel]), 64'(m_phase == 2));
    if (m_phase == 2) begin
      chk("mon_sat_flag", 64'(sflg[sel]), 64'(m_sat));
      for (int i = 0; i < 2; i++)
        for (int j = 0; j < 2; j++)
          chk($sformatf("mon_c%0d%0d", i, j), get_c(sel, i, j), m_c[i][j]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic load(input int a00, input int a01, input int a02,
                      input int a10, input int a11, input int a12,
                      input int b00, input int b01, input int b10,
                      input int b11, input int b20, input int b21);
    a_m[0][0] = 16'(a00); a_m[0][1] = 16'(a01); a_m[0][2] = 16'(a02);
    a_m[1][0] = 16'(a10); a_m[1][1] = 16'(a11); a_m[1][2] = 16'(a12);
    b_m[0][0] = 16'(b00); b_m[0][1] = 16'(b01);
    b_m[1][0] = 16'(b10); b_m[1][1] = 16'(b11);
    b_m[2][0] = 16'(b20); b_m[2][1] = 16'(b21);
  endtask

  // Present a job for one accepting edge, then scramble the inputs.
  task automatic start_job(input int s);
    @(negedge clk);
    sel      = s;
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) for (int k = 0; k < 3; k++) a_m[i][k] = 16'hBEEF;
    for (int k = 0; k < 3; k++) for (int j = 0; j < 2; j++) b_m[k][j] = 16'h8001;
    signed_en = ~signed_en;
    sat_en    = ~sat_en;
  endtask

  task automatic wait_valid(input string name, input int exp_lat);
    int lat;
    lat = 0;
    while (lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (oval[sel]) break;
    end
    chk(name, 64'(lat), 64'(exp_lat));
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("release_valid", 64'(oval[sel]), 64'd0);
    chk("release_ready", 64'(irdy[sel]), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
    signed_en = 1'b0; sat_en = 1'b0;
    load(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("rst_c_zero", 64'(|C0 | |C1 | |C2), 64'd0);
    chk("rst_out_valid", 64'(oval), 64'd0);
    chk("rst_sat_flag", 64'(sflg), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(irdy), 64'h7);

    // Identity B, with five cycles of backpressure.
    load(1, 2, 0, 3, 4, 0, 1, 0, 0, 1, 0, 0);
    signed_en = 1'b1; sat_en = 1'b1;
    start_job(0);
    wait_valid("lat_ident", 9);
    chk("ident_c00", get_c(0, 0, 0), 64'd1);
    chk("ident_c01", get_c(0, 0, 1), 64'd2);
    chk("ident_c10", get_c(0, 1, 0), 64'd3);
    chk("ident_c11", get_c(0, 1, 1), 64'd4);
    repeat (5) begin
      @(negedge clk);
      chk("bp_in_ready", 64'(irdy[0]), 64'd0);
      chk("bp_out_valid", 64'(oval[0]), 64'd1);
      chk("bp_c11", get_c(0, 1, 1), 64'd4);
    end
    release_out();

    // Signed negatives.
    load(-3, 5, 0, 2, -7, 0, 4, -1, 6, 8, 0, 0);
    signed_en = 1'b1; sat_en = 1'b1;
    start_job(0);
    wait_valid("lat_neg", 9);
    chk("neg_c00", get_c(0, 0, 0), 64'd18);
    chk("neg_c01", get_c(0, 0, 1), 64'd43);
    chk("neg_c10", get_c(0, 1, 0), 64'hFFFF_FFDE);
    chk("neg_c11", get_c(0, 1, 1), 64'hFFFF_FFC6);
    release_out();

    // Unsigned full-scale product.
    load(16'hFFFF, 0, 0, 0, 0, 0, 16'hFFFF, 0, 0, 0, 0, 0);
    signed_en = 1'b0; sat_en = 1'b1;
    start_job(0);
    wait_valid("lat_uns", 9);
    chk("uns_c00", get_c(0, 0, 0), 64'hFFFE_0001);
    chk("uns_sat", 64'(sflg[0]), 64'd0);
    release_out();

    // Saturation and wrap with OW=16.
    load(32767, 32767, 0, 0, 0, 0, 32767, 0, 32767, 0, 0, 0);
    signed_en = 1'b1; sat_en = 1'b1;
    start_job(1);
    wait_valid("lat_sat", 9);
    chk("sat_c00", get_c(1, 0, 0), 64'h7FFF);
    chk("sat_flag", 64'(sflg[1]), 64'd1);
    chk("sat_c01", get_c(1, 0, 1), 64'd0);
    release_out();
    load(32767, 32767, 0, 0, 0, 0, 32767, 0, 32767, 0, 0, 0);
    signed_en = 1'b1; sat_en = 1'b0;
    start_job(1);
    wait_valid("lat_wrap", 9);
    chk("wrap_c00", get_c(1, 0, 0), 64'h0002);
    chk("wrap_flag", 64'(sflg[1]), 64'd0);
    release_out();

    // Abort on the third compute cycle.
    load(1, 1, 0, 1, 1, 0, 1, 1, 1, 1, 0, 0);
    signed_en = 1'b1; sat_en = 1'b1;
    start_job(0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_in_ready", 64'(irdy[0]), 64'd1);
    chk("abort_out_valid", 64'(oval[0]), 64'd0);
    repeat (12) begin
      @(negedge clk);
      chk("abort_no_valid", 64'(oval[0]), 64'd0);
    end

    // Reset pulse part-way through a K=3 job, then a fresh job.
    load(1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1);
    signed_en = 1'b1; sat_en = 1'b1;
    start_job(2);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    chk("rstmid_c_zero", 64'(|C2), 64'd0);
    chk("rstmid_out_valid", 64'(oval[2]), 64'd0);
    chk("rstmid_sat_flag", 64'(sflg[2]), 64'd0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_in_ready", 64'(irdy[2]), 64'd1);
    load(1, 2, 3, 4, 5, 6, 1, 0, 0, 1, 1, 1);
    signed_en = 1'b1; sat_en = 1'b1;
    start_job(2);
    wait_valid("lat_rect", 13);
    chk("rect_c00", get_c(2, 0, 0), 64'd4);
    chk("rect_c01", get_c(2, 0, 1), 64'd5);
    chk("rect_c10", get_c(2, 1, 0), 64'd10);
    chk("rect_c11", get_c(2, 1, 1), 64'd11);
    release_out();

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
